// File: rtl/reg_scoreboard.sv
// Register scoreboard for the dual-issue pipeline. It counts in-flight long-latency
// writers per architectural register and raises decode-stage stalls for sources whose
// value cannot yet come from the forwarding network.
module reg_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_fire,
  input  logic        issue_master_long,
  input  logic [4:0]  issue_master_waddr,
  input  logic        issue_slave_long,
  input  logic [4:0]  issue_slave_waddr,
  input  logic        issue_slave_en,
  input  logic        wb_master_valid,
  input  logic [4:0]  wb_master_waddr,
  input  logic        wb_slave_valid,
  input  logic [4:0]  wb_slave_waddr,
  input  logic        flush,
  input  logic [4:0]  rd_master_rs,
  input  logic [4:0]  rd_master_rt,
  input  logic [4:0]  rd_slave_rs,
  input  logic [4:0]  rd_slave_rt,
  output logic        stall_master,
  output logic        stall_slave,
  output logic        issue_full,
  output logic [31:0] pending_vec
);

  // Two spare bits so count + inc never wraps before the overflow compare.
  localparam int unsigned SumW   = CNT_W + 2;
  localparam int unsigned CntMax = (1 << CNT_W) - 1;

  logic [CNT_W-1:0] cnt_q   [32];
  logic [CNT_W-1:0] cnt_d   [32];
  logic [1:0]       inc_raw [32];
  logic [1:0]       dec     [32];
  logic [SumW-1:0]  sum_c   [32];
  logic [31:0]      busy;
  logic             inc_en;

  // Decode per-register issue increments, writeback releases and counter overflow.
  always_comb begin
    issue_full = 1'b0;
    for (int r = 0; r < 32; r++) begin
      inc_raw[r] = 2'd0;
      dec[r]     = 2'd0;
      if (r != 0) begin
        inc_raw[r] = 2'(issue_master_long && (issue_master_waddr == 5'(r)))
                   + 2'(issue_slave_en && issue_slave_long && (issue_slave_waddr == 5'(r)));
        dec[r]     = 2'(wb_master_valid && (wb_master_waddr == 5'(r)))
                   + 2'(wb_slave_valid && (wb_slave_waddr == 5'(r)));
      end
      if ((inc_raw[r] != 2'd0) &&
          ((SumW'(cnt_q[r]) + SumW'(inc_raw[r])) > SumW'(CntMax))) begin
        issue_full = 1'b1;
      end
    end
  end

  // Next counts (release clamps at zero) and the bypassed busy view used for stalls.
  always_comb begin
    inc_en = issue_fire && !issue_full && !flush;
    busy   = '0;
    for (int r = 0; r < 32; r++) begin
      sum_c[r] = SumW'(cnt_q[r]) + (inc_en ? SumW'(inc_raw[r]) : SumW'(0));
      cnt_d[r] = '0;
      if (!flush && (r != 0) && (sum_c[r] > SumW'(dec[r]))) begin
        cnt_d[r] = CNT_W'(sum_c[r] - SumW'(dec[r]));
      end
      // A writeback landing this cycle already satisfies the reader via forwarding.
      busy[r] = (r != 0) && (SumW'(cnt_q[r]) > SumW'(dec[r]));
    end
  end

  // Stall requests: registered counts plus same-cycle wakeups and intra-bundle hazard.
  always_comb begin
    stall_master = busy[rd_master_rs] || busy[rd_master_rt];
    stall_slave  = stall_master || busy[rd_slave_rs] || busy[rd_slave_rt] ||
                   (issue_master_long && (issue_master_waddr != 5'd0) &&
                    ((issue_master_waddr == rd_slave_rs) ||
                     (issue_master_waddr == rd_slave_rt)));
  end

  // Pending view from registered counts only.
  always_comb begin
    pending_vec = '0;
    for (int r = 0; r < 32; r++) begin
      pending_vec[r] = (cnt_q[r] != '0);
    end
  end

  // Counter state; reset clears every pending writer immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

endmodule
